// File: rtl/fp_pkg.sv
// Shared rounding-mode codes, flag indices, operand classes and special-value
// builders for the pipelined IEEE-754 multiplier (formats up to 64 bits wide).
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam int FP_MAX_W = 64;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

    function automatic logic [FP_MAX_W-1:0] fp_exp_ones(input int exp_w, input int frac_w);
        return ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << frac_w;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int frac_w);
        return fp_exp_ones(exp_w, frac_w) | (FP_MAX_W'(1) << (frac_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int frac_w);
        return (FP_MAX_W'(sign) << (exp_w + frac_w)) | fp_exp_ones(exp_w, frac_w);
    endfunction

    // All-ones exponent minus one ulp is exactly the largest finite magnitude.
    function automatic logic [FP_MAX_W-1:0] fp_max_finite(input logic sign, input int exp_w, input int frac_w);
        return (FP_MAX_W'(sign) << (exp_w + frac_w)) | (fp_exp_ones(exp_w, frac_w) - FP_MAX_W'(1));
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational final stage: normalise, round, overflow/underflow select and pack.
// FP_MUL_SUBNORM_EN adds the left/right denormalising shifters for gradual underflow.
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic                        sign,
    input  logic signed [EXP_W+1:0]     exp_in,
    input  logic [2*FRAC_W+1:0]         prod,
    input  logic [1:0]                  rm,
    output logic [EXP_W+FRAC_W:0]       result,
    output logic [3:0]                  flags
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int MAN_W = FRAC_W + 1;
    localparam int P_W   = 2 * MAN_W;
    localparam int E_W   = EXP_W + 2;
    localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
    localparam logic signed [E_W-1:0] E_EMAX = E_W'(2**EXP_W - 1);

    function automatic logic round_up(input logic [1:0] mode, input logic sgn,
                                      input logic lsb, input logic g, input logic r, input logic s);
        case (mode)
            RM_RNE:  return g && (r || s || lsb);
            RM_RTZ:  return 1'b0;
            RM_RUP:  return !sgn && (g || r || s);
            default: return sgn && (g || r || s);
        endcase
    endfunction

`ifdef FP_MUL_SUBNORM_EN
    function automatic int lzc(input logic [P_W-1:0] v);
        int n;
        n = P_W;
        for (int i = 0; i < P_W; i++) begin
            if (v[i]) n = P_W - 1 - i;
        end
        return n;
    endfunction

    int sh;
`endif

    logic [P_W-1:0]          m;
    logic signed [E_W-1:0]   e;
    logic signed [E_W-1:0]   e_out;
    logic                    sticky;
    logic [MAN_W-1:0]        kept;
    logic [MAN_W:0]          mr;
    logic [FRAC_W-1:0]       frac;
    logic                    g, r, s, nx, inc, to_inf;

    always_comb begin
        result = '0;
        flags  = '0;
        sticky = 1'b0;
        // Leading one is placed at the top bit of m; at most a one-bit shift for normal operands.
        if (prod[P_W-1]) begin
            m = prod;
            e = exp_in + E_ONE;
        end else begin
            m = prod << 1;
            e = exp_in;
        end
`ifdef FP_MUL_SUBNORM_EN
        sh = lzc(m);
        if (e <= E_ONE) sh = 0;
        else if (sh > int'(e) - 1) sh = int'(e) - 1;
        m = m << sh;
        e = e - E_W'(sh);
        if (e < E_ONE) begin
            sh = 1 - int'(e);
            if (sh > P_W) sh = P_W;
            sticky = |(m & ~({P_W{1'b1}} << sh));
            m = m >> sh;
            e = E_ONE;
        end
`endif
        kept = m[P_W-1 -: MAN_W];
        g    = m[FRAC_W];
        r    = m[FRAC_W-1];
        s    = sticky | (|m[FRAC_W-2:0]);
        nx   = g | r | s;
        inc  = round_up(rm, sign, kept[0], g, r, s);
        mr   = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
        // A carry out of the mantissa re-normalises; a missing hidden bit means subnormal.
        if (mr[MAN_W]) begin
            e_out = e + E_ONE;
            frac  = mr[FRAC_W:1];
        end else begin
            e_out = mr[FRAC_W] ? e : '0;
            frac  = mr[FRAC_W-1:0];
        end
        to_inf = (rm == RM_RNE) || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
        if (e_out >= E_EMAX) begin
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
            result = to_inf ? W'(fp_inf(sign, EXP_W, FRAC_W)) : W'(fp_max_finite(sign, EXP_W, FRAC_W));
        end
`ifndef FP_MUL_SUBNORM_EN
        else if (e_out < E_ONE) begin
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
            result = {sign, {(W-1){1'b0}}};
        end
`endif
        else begin
            flags[FLG_NX] = nx;
            flags[FLG_UF] = nx && (e_out == '0);
            result = {sign, e_out[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with valid/ready backpressure and a global enable.
// FP_MUL_SUBNORM_EN selects gradual underflow; otherwise subnormals flush to zero.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   A,
    input  logic [EXP_W+FRAC_W:0]   B,
    input  logic [1:0]              rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [3:0]              flags
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int MAN_W = FRAC_W + 1;
    localparam int P_W   = 2 * MAN_W;
    localparam int E_W   = EXP_W + 2;
    localparam logic signed [E_W-1:0] E_BIAS = E_W'(2**(EXP_W-1) - 1);

    function automatic fp_class_e classify(input logic [W-1:0] x);
        if (x[W-2:FRAC_W] == '1)
            return (x[FRAC_W-1:0] == '0) ? INF : (x[FRAC_W-1] ? QNAN : SNAN);
        else if (x[W-2:FRAC_W] == '0)
            return (x[FRAC_W-1:0] == '0) ? ZERO : SUB;
        else
            return NORM;
    endfunction

    logic advance;
    logic vld_p1, vld_p2, vld_p3;

    fp_class_e             cls_a, cls_b;
    logic                  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                  sign_s1, spec_s1;
    logic [W-1:0]          spec_res_s1;
    logic [3:0]            spec_flg_s1;
    logic [EXP_W-1:0]      ea, eb;
    logic signed [E_W-1:0] exp_s1;
    logic [MAN_W-1:0]      man_a_s1, man_b_s1;

    logic                  sign_p1, spec_p1;
    logic signed [E_W-1:0] exp_p1;
    logic [MAN_W-1:0]      man_a_p1, man_b_p1;
    logic [1:0]            rm_p1;
    logic [W-1:0]          spec_res_p1;
    logic [3:0]            spec_flg_p1;

    logic                  sign_p2, spec_p2;
    logic signed [E_W-1:0] exp_p2;
    logic [P_W-1:0]        prod_p2;
    logic [1:0]            rm_p2;
    logic [W-1:0]          spec_res_p2;
    logic [3:0]            spec_flg_p2;

    logic [W-1:0]          rn_result;
    logic [3:0]            rn_flags;

    assign advance   = en && (!vld_p3 || out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_p3;

    // S1: classify operands, resolve special cases, add exponents.
    always_comb begin
        cls_a   = classify(A);
        cls_b   = classify(B);
`ifdef FP_MUL_SUBNORM_EN
        zero_a  = (cls_a == ZERO);
        zero_b  = (cls_b == ZERO);
`else
        zero_a  = (cls_a == ZERO) || (cls_a == SUB);
        zero_b  = (cls_b == ZERO) || (cls_b == SUB);
`endif
        inf_a   = (cls_a == INF);
        inf_b   = (cls_b == INF);
        nan_a   = (cls_a == QNAN) || (cls_a == SNAN);
        nan_b   = (cls_b == QNAN) || (cls_b == SNAN);
        sign_s1 = A[W-1] ^ B[W-1];
        spec_s1     = 1'b1;
        spec_res_s1 = '0;
        spec_flg_s1 = '0;
        if (nan_a || nan_b) begin
            spec_res_s1 = W'(fp_qnan(EXP_W, FRAC_W));
            spec_flg_s1[FLG_NV] = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            spec_res_s1 = W'(fp_qnan(EXP_W, FRAC_W));
            spec_flg_s1[FLG_NV] = 1'b1;
        end else if (inf_a || inf_b) begin
            spec_res_s1 = W'(fp_inf(sign_s1, EXP_W, FRAC_W));
        end else if (zero_a || zero_b) begin
            spec_res_s1 = {sign_s1, {(W-1){1'b0}}};
        end else begin
            spec_s1 = 1'b0;
        end
        ea       = (cls_a == SUB) ? EXP_W'(1) : A[W-2:FRAC_W];
        eb       = (cls_b == SUB) ? EXP_W'(1) : B[W-2:FRAC_W];
        exp_s1   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;
        man_a_s1 = {cls_a == NORM, A[FRAC_W-1:0]};
        man_b_s1 = {cls_b == NORM, B[FRAC_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // S1 -> S2 registers, then the full mantissa product into S2 -> S3.
    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p1     <= sign_s1;
            spec_p1     <= spec_s1;
            exp_p1      <= exp_s1;
            man_a_p1    <= man_a_s1;
            man_b_p1    <= man_b_s1;
            rm_p1       <= rm;
            spec_res_p1 <= spec_res_s1;
            spec_flg_p1 <= spec_flg_s1;

            sign_p2     <= sign_p1;
            spec_p2     <= spec_p1;
            exp_p2      <= exp_p1;
            prod_p2     <= P_W'(man_a_p1) * P_W'(man_b_p1);
            rm_p2       <= rm_p1;
            spec_res_p2 <= spec_res_p1;
            spec_flg_p2 <= spec_flg_p1;
        end
    end

    fp_round_norm #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round_norm (
        .sign   (sign_p2),
        .exp_in (exp_p2),
        .prod   (prod_p2),
        .rm     (rm_p2),
        .result (rn_result),
        .flags  (rn_flags)
    );

    // S3 output register: only real results overwrite it, so it holds across stalls and bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (advance && vld_p2) begin
            result <= spec_p2 ? spec_res_p2 : rn_result;
            flags  <= spec_p2 ? spec_flg_p2 : rn_flags;
        end
    end

endmodule
